// File: rtl/cam_sync_fifo.sv
// ============================================================================
// cam_sync_fifo
// ----------------------------------------------------------------------------
// Single-clock pixel FIFO for the wb_cam capture path. It buffers camera words
// between the sensor interface (writer) and the Wishbone/DMA drain (reader).
// It supports concurrent read and write, reports its fill level, and drives
// registered almost-full/almost-empty thresholds plus sticky overflow and
// underflow flags.
//
// Build option:
//   CAM_FIFO_FWFT_EN  defined   -> first-word-fall-through. data_out shows the
//                                  head word whenever empty=0, and rd consumes
//                                  it. The output register counts toward
//                                  level, so total capacity stays DEPTH.
//                     undefined -> standard mode. data_out is loaded on the
//                                  edge that accepts rd (read latency 1) and
//                                  holds its value otherwise.
//
// Parameters:
//   DW         data word width
//   AW         address width, DEPTH = 2**AW
//   AF_THRESH  almost_full  = (level >= AF_THRESH)
//   AE_THRESH  almost_empty = (level <= AE_THRESH)
//
// Ports:
//   Pclk          in   1     clock, rising edge
//   rst           in   1     synchronous active-high reset, dominates all
//   wr            in   1     write request
//   data_in       in   DW    write data
//   rd            in   1     read request (pop)
//   data_out      out  DW    registered read data
//   empty         out  1     no words stored
//   full          out  1     DEPTH words stored
//   level         out  AW+1  words stored, 0..DEPTH
//   almost_full   out  1     level >= AF_THRESH
//   almost_empty  out  1     level <= AE_THRESH
//   overflow      out  1     sticky: wr while full without a same-cycle pop
//   underflow     out  1     sticky: rd while empty
//   clr_err       in   1     clears overflow/underflow (a new set wins)
//
// Handshake: a request is accepted on the rising edge where it is asserted and
// its accept term is true. The terms are:
//   rd_ok = rd & ~empty
//   wr_ok = wr & (~full | rd_ok)
// A write while full is accepted only when a pop happens in the same cycle.
// A rejected request changes nothing except the sticky error flags.
// ============================================================================
module cam_sync_fifo #(
    parameter int DW        = 10,
    parameter int AW        = 10,
    parameter int AF_THRESH = 2**AW - 4,
    parameter int AE_THRESH = 4
) (
    input  logic          Pclk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] data_in,
    input  logic          rd,
    output logic [DW-1:0] data_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_L    = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_L    = AE_THRESH[AW:0];

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] w_ptr_q, w_ptr_d;
    logic [AW-1:0] r_ptr_q, r_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          empty_q, full_q, af_q, ae_q;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_ok, rd_ok, mem_we;

`ifdef CAM_FIFO_FWFT_EN
    // Words held in the memory array, i.e. excluding the output register.
    // Whenever level > 0 the output register holds the head word, so it is
    // occupied exactly when empty_q is low.
    logic [AW:0] mem_cnt;
    logic        need_load;
`endif

    always_comb begin
        rd_ok = rd & ~empty_q;
        wr_ok = wr & (~full_q | rd_ok);

        level_d = level_q;
        if (wr_ok && !rd_ok)
            level_d = level_q + 1'b1;
        else if (rd_ok && !wr_ok)
            level_d = level_q - 1'b1;

        mem_we     = wr_ok;
        r_ptr_d    = r_ptr_q;
        data_out_d = data_out_q;

`ifdef CAM_FIFO_FWFT_EN
        mem_cnt   = level_q - {{AW{1'b0}}, ~empty_q};
        // The output register needs a new head when it is empty or is being
        // popped this cycle.
        need_load = empty_q | rd_ok;
        if (need_load && (mem_cnt != '0)) begin
            data_out_d = mem_q[r_ptr_q];
            r_ptr_d    = r_ptr_q + 1'b1;
        end else if (need_load && wr_ok) begin
            // Memory is empty: the incoming word bypasses straight to the head.
            data_out_d = data_in;
            mem_we     = 1'b0;
        end
`else
        if (rd_ok) begin
            // When the FIFO is full and both rd and wr are accepted, the write
            // and read slots coincide. The old word is read here because the
            // memory write lands at the same edge.
            data_out_d = mem_q[r_ptr_q];
            r_ptr_d    = r_ptr_q + 1'b1;
        end
`endif

        w_ptr_d = w_ptr_q + {{(AW-1){1'b0}}, mem_we};

        // A set in the same cycle overrides clr_err.
        ovf_d = clr_err ? 1'b0 : ovf_q;
        if (wr && full_q && !rd_ok)
            ovf_d = 1'b1;
        udf_d = clr_err ? 1'b0 : udf_q;
        if (rd && empty_q)
            udf_d = 1'b1;
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            level_q    <= '0;
            data_out_q <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= (AF_L == '0);
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            level_q    <= level_d;
            data_out_q <= data_out_d;
            // Status flags come from the next-state level, so they line up
            // with level on the same edge.
            empty_q    <= (level_d == '0);
            full_q     <= (level_d == DEPTH_L);
            af_q       <= (level_d >= AF_L);
            ae_q       <= (level_d <= AE_L);
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // The storage array is not reset. Writes are blocked while rst is high.
    always_ff @(posedge Pclk) begin
        if (!rst && mem_we)
            mem_q[w_ptr_q] <= data_in;
    end

    assign data_out     = data_out_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_cam_sync_fifo.sv
// ============================================================================
// tb_cam_sync_fifo
// ----------------------------------------------------------------------------
// Directed bench for cam_sync_fifo with DW=10, AW=4 (DEPTH=16), AF_THRESH=12
// and AE_THRESH=4. Define CAM_FIFO_FWFT_EN for both the RTL and this bench to
// exercise the first-word-fall-through build.
// ============================================================================
module tb_cam_sync_fifo;

    localparam int DW = 10;
    localparam int AW = 4;

    logic          Pclk = 1'b0;
    logic          rst  = 1'b1;
    logic          wr   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd   = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_out;
    logic          empty, full, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   level;

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];

    cam_sync_fifo #(
        .DW(DW), .AW(AW), .AF_THRESH(12), .AE_THRESH(4)
    ) dut (
        .Pclk(Pclk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(data_out), .empty(empty), .full(full), .level(level),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    // clock / reset
    always #5 Pclk = ~Pclk;

    // Advance one rising edge. Outputs are then sampled 1 ns after that edge.
    task automatic step();
        @(posedge Pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic push(input logic [DW-1:0] d);
        wr = 1'b1; rd = 1'b0; data_in = d;
        step();
        wr = 1'b0;
    endtask

    // Pop one word and check it against the expected value.
    task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
`ifdef CAM_FIFO_FWFT_EN
        check(tag, 32'(data_out), 32'(exp));
        rd = 1'b1; step(); rd = 1'b0;
`else
        rd = 1'b1; step(); rd = 1'b0;
        check(tag, 32'(data_out), 32'(exp));
`endif
    endtask

    logic [DW-1:0] d;
    logic [DW-1:0] hold;

    initial begin
        // 1: reset
        rst = 1'b1; step(); step(); rst = 1'b0;
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_level", 32'(level), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);

        // 2: fill 0x001..0x010, thresholds at levels 5 and 12
        for (int i = 1; i <= 16; i++) begin
            push(DW'(i));
            check("fill_level", 32'(level), 32'(i));
            check("fill_ae", 32'(almost_empty), (i <= 4) ? 1 : 0);
            check("fill_af", 32'(almost_full), (i >= 12) ? 1 : 0);
            check("fill_full", 32'(full), (i == 16) ? 1 : 0);
            check("fill_empty", 32'(empty), 0);
        end
        push(10'h2AA);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_level", 32'(level), 16);
        check("ovf_full", 32'(full), 1);

        // 3: concurrent rd+wr while full, with overflow cleared first
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("clr_ovf", 32'(overflow), 0);
`ifdef CAM_FIFO_FWFT_EN
        check("conc_head", 32'(data_out), 32'h001);
        rd = 1'b1; wr = 1'b1; data_in = 10'h3FF; step(); rd = 1'b0; wr = 1'b0;
`else
        rd = 1'b1; wr = 1'b1; data_in = 10'h3FF; step(); rd = 1'b0; wr = 1'b0;
        check("conc_dout", 32'(data_out), 32'h001);
`endif
        check("conc_level", 32'(level), 16);
        check("conc_ovf", 32'(overflow), 0);
        check("conc_full", 32'(full), 1);
        for (int i = 2; i <= 16; i++)
            pop_chk("drain", DW'(i));
        pop_chk("drain_last", 10'h3FF);
        check("drain_empty", 32'(empty), 1);
        check("drain_level", 32'(level), 0);
        check("drain_udf", 32'(underflow), 0);

`ifndef CAM_FIFO_FWFT_EN
        // data_out holds when no pop occurs
        step();
        check("dout_hold", 32'(data_out), 32'h3FF);
`endif

        // 4: wrap, 8 bursts of 5 pushes then 5 pops (40 words)
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 5; k++) begin
                d = DW'((b * 5 + k) * 37 + 5);
                exp_q.push_back(d);
                push(d);
            end
            check("wrap_level5", 32'(level), 5);
            for (int k = 0; k < 5; k++)
                pop_chk("wrap_data", exp_q.pop_front());
        end
        check("wrap_empty", 32'(empty), 1);
        check("wrap_ovf", 32'(overflow), 0);
        check("wrap_udf", 32'(underflow), 0);

        // 5: underflow set, clear, and set beating clear
        hold = data_out;
        rd = 1'b1; step(); rd = 1'b0;
        check("udf_set", 32'(underflow), 1);
        check("udf_level", 32'(level), 0);
        check("udf_dout", 32'(data_out), 32'(hold));
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("udf_clr", 32'(underflow), 0);
        rd = 1'b1; clr_err = 1'b1; step(); rd = 1'b0; clr_err = 1'b0;
        check("udf_prio", 32'(underflow), 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        rd = 1'b1; wr = 1'b1; data_in = 10'h0AB; step(); rd = 1'b0; wr = 1'b0;
        check("rdwr_empty_level", 32'(level), 1);
        check("rdwr_empty_udf", 32'(underflow), 1);
        pop_chk("rdwr_empty_data", 10'h0AB);
        clr_err = 1'b1; step(); clr_err = 1'b0;

`ifdef CAM_FIFO_FWFT_EN
        // 6: first word falls through without rd
        push(10'h155);
        check("fwft_empty", 32'(empty), 0);
        check("fwft_dout", 32'(data_out), 32'h155);
        rd = 1'b1; step(); rd = 1'b0;
        check("fwft_drain", 32'(empty), 1);
`endif

        // 7: reset mid-transfer, then confirm the pointers restart
        push(10'h011); push(10'h022); push(10'h033);
        rst = 1'b1; wr = 1'b1; data_in = 10'h044; step(); rst = 1'b0; wr = 1'b0;
        check("mrst_level", 32'(level), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_dout", 32'(data_out), 0);
        push(10'h066);
        pop_chk("mrst_data", 10'h066);
        check("mrst_end", 32'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
